hpc1_rand_feeder: RTL

- Fresh-randomness source for the order-4 (5-share) HPC1 multiplier, directly upstream of it.
- Every cycle it supplies one bundle: the four refresh masks r0..r3 and the ten pairwise masks p01..p34. The multiplier derives r4 itself.
- 14 independent 16-bit Galois LFSR lanes, seeded over a seed port.
- Registered valid/ready output. A forced reseed happens after a programmable number of bundles.

---
 rtl/hpc1_rand_feeder_if.sv | 35 +++
 rtl/hpc1_rand_feeder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hpc1_rand_feeder_if.sv
// Seed port and mask-bundle port of the HPC1 randomness feeder.
// The master side is the feeder. The slave side is its environment: the seeder and the multiplier.
interface hpc1_rand_feeder_if #(
  parameter int W = 8
);
  logic         seed_valid;
  logic         seed_ready;
  logic [3:0]   seed_idx;
  logic [15:0]  seed_data;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r0, r1, r2, r3;
  logic [W-1:0] p01, p02, p03, p04, p12, p13, p14, p23, p24, p34;

  logic         reseed_req;
  logic         running;
  logic [15:0]  bundle_cnt;

  modport master (
    input  seed_valid, seed_idx, seed_data, out_ready,
    output seed_ready, out_valid,
    output r0, r1, r2, r3,
    output p01, p02, p03, p04, p12, p13, p14, p23, p24, p34,
    output reseed_req, running, bundle_cnt
  );

  modport slave (
    output seed_valid, seed_idx, seed_data, out_ready,
    input  seed_ready, out_valid,
    input  r0, r1, r2, r3,
    input  p01, p02, p03, p04, p12, p13, p14, p23, p24, p34,
    input  reseed_req, running, bundle_cnt
  );
endinterface

// File: rtl/hpc1_rand_feeder.sv
// Fresh-mask source for the order-4 HPC1 multiplier: 14 Galois LFSR lanes.
// Each lane emits one W-bit word per bundle. A reseed is forced after a programmable number of bundles.
module hpc1_rand_feeder_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_we,
  input  logic [15:0]  seed_data,
  input  logic         load,
  output logic [W-1:0] word
);
  logic [15:0]  s_q;
  logic [15:0]  s_nxt;
  logic [W-1:0] w_nxt;

  // Unroll W Galois steps. Bit i of the word is the lsb that leaves on step i.
  always_comb begin
    s_nxt = s_q;
    w_nxt = '0;
    for (int i = 0; i < W; i++) begin
      w_nxt[i] = s_nxt[0];
      s_nxt    = {1'b0, s_nxt[15:1]} ^ (s_nxt[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      word <= '0;
    end else if (seed_we) begin
      s_q  <= seed_data;
    end else if (load) begin
      s_q  <= s_nxt;
      word <= w_nxt;
    end
  end
endmodule

module hpc1_rand_feeder #(
  parameter int W               = 8,
  parameter int RESEED_INTERVAL = 1024
) (
  input logic                clk,
  input logic                rst_n,
  hpc1_rand_feeder_if.master bus
);
  localparam int NUM_LANES = 14;

  localparam logic [0:0] ST_SEED = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam bit          RESEED_EN = (RESEED_INTERVAL > 0) && (RESEED_INTERVAL <= 65535);
  localparam logic [15:0] RESEED_AT = 16'(RESEED_INTERVAL);

  logic [0:0]                    state;
  logic [NUM_LANES-1:0]          seed_mask;
  logic                          out_valid_q;
  logic [15:0]                   cnt_q;

  logic [NUM_LANES-1:0]          seed_we;
  logic [NUM_LANES-1:0][W-1:0]   word;
  logic [15:0]                   seed_val;
  logic                          seed_hit;
  logic                          hs;
  logic                          load;
  logic                          force_reseed;
  logic [15:0]                   cnt_inc;

  // An all-zero seed would freeze a lane, so it is swapped for a fixed nonzero value.
  assign seed_val = (bus.seed_data == 16'h0000) ? 16'hACE1 : bus.seed_data;
  assign seed_hit = (state == ST_SEED) && bus.seed_valid && (bus.seed_idx < 4'(NUM_LANES));

  assign hs           = (state == ST_RUN) && out_valid_q && bus.out_ready;
  assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign force_reseed = RESEED_EN && hs && (cnt_inc == RESEED_AT);
  // The handshake that triggers a reseed also suppresses the refill, so no stale bundle is shown.
  assign load = (state == ST_RUN) && (!out_valid_q || bus.out_ready) && !force_reseed;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign seed_we[g] = seed_hit && (bus.seed_idx == 4'(g));

    hpc1_rand_feeder_lane #(.W(W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_we   (seed_we[g]),
      .seed_data (seed_val),
      .load      (load),
      .word      (word[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEED;
      seed_mask   <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        ST_SEED: begin
          seed_mask <= seed_mask | seed_we;
          if (&seed_mask) begin
            state <= ST_RUN;
            cnt_q <= '0;
          end
        end
        default: begin
          if (hs) cnt_q <= cnt_inc;
          if (force_reseed) begin
            state       <= ST_SEED;
            seed_mask   <= '0;
            out_valid_q <= 1'b0;
          end else if (load) begin
            out_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.seed_ready = (state == ST_SEED);
  assign bus.reseed_req = (state == ST_SEED);
  assign bus.running    = (state == ST_RUN);
  assign bus.out_valid  = out_valid_q;
  assign bus.bundle_cnt = cnt_q;

  assign bus.r0  = word[0];
  assign bus.r1  = word[1];
  assign bus.r2  = word[2];
  assign bus.r3  = word[3];
  assign bus.p01 = word[4];
  assign bus.p02 = word[5];
  assign bus.p03 = word[6];
  assign bus.p04 = word[7];
  assign bus.p12 = word[8];
  assign bus.p13 = word[9];
  assign bus.p14 = word[10];
  assign bus.p23 = word[11];
  assign bus.p24 = word[12];
  assign bus.p34 = word[13];
endmodule
